// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM encodings and sizing helpers for bus arbiters.
package bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, TURN = 2'd2} state_e;
  localparam int TURN_DEFAULT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) if ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int bits_for(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first request at or after ptr wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);
  logic [PW-1:0] j;
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = PW'((int'(ptr_i) + k) % N);
      if (req_i[j]) idx_o = j;
    end
    any_o = |req_i;
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/bus_drive_arbiter.sv
// bus_drive_arbiter: round-robin owner of a shared tristate bus with turnaround gap and hold limit.
module bus_drive_arbiter
  import bus_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int TURN_CYCLES = TURN_DEFAULT,
  parameter int MAX_HOLD    = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       grant,
  output logic [bits_for(CHANNELS)-1:0] owner,
  output logic                      drive_en,
  inout  wire  [WIDTH-1:0]          bus
);
  localparam int OW = bits_for(CHANNELS);
  localparam int HW = bits_for(MAX_HOLD + 1);
  localparam int TW = bits_for(TURN_CYCLES + 1);
  state_e               state_q;
  logic [CHANNELS-1:0]  grant_q;
  logic [OW-1:0]        owner_q;
  logic [OW-1:0]        ptr_q;
  logic [WIDTH-1:0]     data_q;
  logic [HW-1:0]        hold_q;
  logic [TW-1:0]        turn_q;
  logic [WIDTH-1:0]     ch_data [CHANNELS];
  logic [CHANNELS-1:0]  pick_gnt;
  logic [OW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 others;
  logic                 release_now;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign ch_data[c] = data_in[c*WIDTH +: WIDTH];
  end
  rr_pick #(.N(CHANNELS), .PW(OW)) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );
  assign others      = |(req & ~grant_q);
  assign release_now = !req[owner_q] || (MAX_HOLD != 0 && hold_q == HW'(MAX_HOLD) && others);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else if (state_q == DRIVE) begin
      if (release_now) begin
        state_q <= TURN;
        grant_q <= '0;
        ptr_q   <= OW'((int'(owner_q) + 1) % CHANNELS);
        turn_q  <= TW'(1);
      end else begin
        data_q <= ch_data[owner_q];
        if (MAX_HOLD != 0 && hold_q != HW'(MAX_HOLD)) hold_q <= hold_q + HW'(1);
      end
    end else if (state_q == TURN && turn_q != TW'(TURN_CYCLES)) begin
      turn_q <= turn_q + TW'(1);
    end else if (pick_any) begin
      state_q <= DRIVE;
      grant_q <= pick_gnt;
      owner_q <= pick_idx;
      data_q  <= ch_data[pick_idx];
      hold_q  <= HW'(1);
    end else begin
      state_q <= IDLE;
    end
  end
  assign grant    = grant_q;
  assign owner    = owner_q;
  assign drive_en = |grant_q;
  assign bus      = drive_en ? data_q : 'z;
endmodule

// File: tb/tb_bus_drive_arbiter.sv
// tb_bus_drive_arbiter: table vectors, directed corner sequences and random stimulus vs an ownership model.
module tb_bus_drive_arbiter;
  typedef struct {
    int          owner;
    int          ptr;
    int          gap;
    int          run;
    logic [15:0] data;
  } mdl_t;
  typedef struct {
    logic        rn;
    logic [3:0]  req;
    logic [63:0] din;
    logic [3:0]  g;
    logic        drv;
    logic [1:0]  own;
    logic [15:0] bus;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_a = 1'b0, rst_b = 1'b0;
  logic [3:0]  req_a = '0, req_b = '0;
  logic [63:0] din_a = '0, din_b = '0;
  logic [3:0]  grant_a, grant_b;
  logic [1:0]  owner_a, owner_b;
  logic        drv_a, drv_b;
  wire  [15:0] bus_a, bus_b;
  int          n_tests = 0, n_fail = 0;
  mdl_t        ma, mb;
  vec_t        tbl [12];
  always #5 clk = ~clk;
  bus_drive_arbiter #(.WIDTH(16), .CHANNELS(4), .TURN_CYCLES(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .reset_n(rst_a), .req(req_a), .data_in(din_a),
    .grant(grant_a), .owner(owner_a), .drive_en(drv_a), .bus(bus_a)
  );
  bus_drive_arbiter #(.WIDTH(16), .CHANNELS(4), .TURN_CYCLES(3), .MAX_HOLD(0)) dut_b (
    .clk(clk), .reset_n(rst_b), .req(req_b), .data_in(din_b),
    .grant(grant_b), .owner(owner_b), .drive_en(drv_b), .bus(bus_b)
  );
  function automatic mdl_t step(mdl_t m, logic rn, logic [3:0] r, logic [63:0] d, int tc, int mh);
    mdl_t n;
    bit   other;
    n = m;
    if (!rn) begin
      n.owner = -1; n.ptr = 0; n.gap = 0; n.run = 0; n.data = '0;
      return n;
    end
    if (m.owner >= 0) begin
      other = 0;
      for (int c = 0; c < 4; c++) if (c != m.owner && r[c]) other = 1;
      if (!r[m.owner] || (mh != 0 && m.run >= mh && other)) begin
        n.ptr = (m.owner + 1) % 4;
        n.owner = -1;
        n.gap = tc;
      end else begin
        n.data = d[m.owner*16 +: 16];
        n.run = m.run + 1;
      end
    end else if (m.gap > 1) begin
      n.gap = m.gap - 1;
    end else begin
      n.gap = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m.ptr + k) % 4;
        if (r[c]) begin
          n.owner = c; n.data = d[c*16 +: 16]; n.run = 1;
          break;
        end
      end
    end
    return n;
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic check_dut(string nm, mdl_t m, logic [3:0] g, logic de, logic [1:0] ow, logic [15:0] b);
    chk({nm, "_grant"}, 32'(g), (m.owner >= 0) ? (32'(1) << m.owner) : 32'(0));
    chk({nm, "_drive_en"}, 32'(de), 32'(m.owner >= 0));
    chk({nm, "_onehot"}, 32'(de == |g && $onehot0(g)), 32'(1));
    if (m.owner >= 0) begin
      chk({nm, "_owner"}, 32'(ow), 32'(m.owner));
      chk({nm, "_bus"}, 32'(b), 32'(m.data));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    ma = step(ma, rst_a, req_a, din_a, 1, 4);
    mb = step(mb, rst_b, req_b, din_b, 3, 0);
    @(negedge clk);
    check_dut("A", ma, grant_a, drv_a, owner_a, bus_a);
    check_dut("B", mb, grant_b, drv_b, owner_b, bus_b);
  endtask
  initial begin
    ma = '{owner: -1, ptr: 0, gap: 0, run: 0, data: '0};
    mb = ma;
    tbl[0]  = '{1'b0, 4'h0, 64'h0, 4'h0, 1'b0, 2'd0, 16'h0};
    tbl[1]  = '{1'b1, 4'h2, 64'h0000_0000_1234_0000, 4'h2, 1'b1, 2'd1, 16'h1234};
    tbl[2]  = '{1'b1, 4'h2, 64'h0000_0000_5678_0000, 4'h2, 1'b1, 2'd1, 16'h5678};
    tbl[3]  = '{1'b1, 4'h2, 64'h0000_0000_BEEF_0000, 4'h2, 1'b1, 2'd1, 16'hBEEF};
    tbl[4]  = '{1'b0, 4'h2, 64'h0000_0000_BEEF_0000, 4'h0, 1'b0, 2'd0, 16'h0};
    tbl[5]  = '{1'b1, 4'h0, 64'h0, 4'h0, 1'b0, 2'd0, 16'h0};
    tbl[6]  = '{1'b1, 4'h0, 64'h0, 4'h0, 1'b0, 2'd0, 16'h0};
    tbl[7]  = '{1'b1, 4'h9, 64'h3333_0000_0000_AAAA, 4'h1, 1'b1, 2'd0, 16'hAAAA};
    tbl[8]  = '{1'b1, 4'h8, 64'h3333_0000_0000_AAAA, 4'h0, 1'b0, 2'd0, 16'h0};
    tbl[9]  = '{1'b1, 4'h8, 64'h3333_0000_0000_AAAA, 4'h8, 1'b1, 2'd3, 16'h3333};
    tbl[10] = '{1'b1, 4'h0, 64'h0, 4'h0, 1'b0, 2'd0, 16'h0};
    tbl[11] = '{1'b1, 4'h0, 64'h0, 4'h0, 1'b0, 2'd0, 16'h0};
    for (int i = 0; i < 12; i++) begin
      rst_a = tbl[i].rn; req_a = tbl[i].req; din_a = tbl[i].din;
      tick();
      chk("tbl_grant", 32'(grant_a), 32'(tbl[i].g));
      chk("tbl_drive_en", 32'(drv_a), 32'(tbl[i].drv));
      if (tbl[i].drv) begin
        chk("tbl_owner", 32'(owner_a), 32'(tbl[i].own));
        chk("tbl_bus", 32'(bus_a), 32'(tbl[i].bus));
      end
    end
    din_a = 64'h4444_3333_2222_1111;
    req_a = 4'hF;
    tick();
    for (int i = 0; i < 5; i++) begin
      int cur;
      cur = i % 4;
      chk("rr_owner", 32'(owner_a), 32'(cur));
      tick();
      req_a[cur] = 1'b0;
      tick();
      chk("rr_gap", 32'(drv_a), 32'(0));
      req_a = 4'hF;
      tick();
    end
    req_a = 4'h0; tick(); tick();
    req_a = 4'h1; tick();
    chk("hold_first", 32'(owner_a), 32'(0));
    req_a = 4'h5;
    repeat (3) begin
      tick();
      chk("hold_keep", 32'(owner_a) | (32'(drv_a) << 4), 32'h10);
    end
    tick();
    chk("hold_release", 32'(drv_a), 32'(0));
    tick();
    chk("hold_next", 32'(grant_a), 32'h4);
    req_a = 4'h0; tick();
    req_a = 4'h9; tick();
    chk("wrap_ch3", 32'(grant_a), 32'h8);
    req_a = 4'h1; tick(); tick();
    chk("wrap_ch0", 32'(grant_a), 32'h1);
    req_a = 4'h0; tick(); tick();
    rst_b = 1'b1; din_b = 64'hDDDD_CCCC_BBBB_0C0C; req_b = 4'h1;
    tick();
    chk("unl_first", 32'(grant_b), 32'h1);
    req_b = 4'h5;
    repeat (20) tick();
    chk("unl_keep", 32'(grant_b), 32'h1);
    req_b = 4'h8;
    tick();
    chk("turn3_rel", 32'(drv_b), 32'(0));
    tick(); tick();
    chk("turn3_gap", 32'(drv_b), 32'(0));
    tick();
    chk("turn3_ch3", 32'(grant_b), 32'h8);
    req_b = 4'hA;
    repeat (3) tick();
    chk("turn3_hold", 32'(owner_b), 32'(3));
    req_b = 4'h2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("turn3_z", 32'(drv_b), 32'(0));
    end
    tick();
    chk("turn3_ch1", 32'(grant_b), 32'h2);
    for (int i = 0; i < 3000; i++) begin
      rst_a = ($urandom_range(63) != 0);
      rst_b = ($urandom_range(63) != 0);
      if ($urandom_range(3) == 0) req_a = 4'($urandom);
      if ($urandom_range(3) == 0) req_b = 4'($urandom);
      din_a = {$urandom, $urandom};
      din_b = {$urandom, $urandom};
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
